// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue
//   Fetch stage: sequential PC generator, IROM request port with credit-based
//   flow control, and a DEPTH-entry in-order fetch queue feeding decode.
//   Interrupt and branch redirects flush the queue. In-flight responses that
//   belong to the old path are counted and discarded as they return.
// Ports
//   clk, resetn                         clock (rising edge), async active-low reset
//   req_pc_o, req_valid_o, req_ready_i  IROM request handshake
//   rsp_inst_i, rsp_valid_i             IROM response, in request order, never stalled
//   int_i, int_pc_i                     interrupt redirect pulse and target
//   redirect_i, redirect_pc_i           branch/jump redirect pulse and target
//   inst_valid_o, inst_ready_i          queue head handshake to decode
//   inst_o, pc_o, pc_4_o                head instruction, its PC, PC + 4
module fetch_pc_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] req_pc_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  input  logic [31:0] rsp_inst_i,
  input  logic        rsp_valid_i,
  input  logic        int_i,
  input  logic [31:0] int_pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_4_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);

  logic [CW-1:0] outstanding_q, count_q, drop_q;
  logic [CW-1:0] outstanding_nxt, count_nxt, drop_nxt;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
  logic [31:0]   req_pc_q, req_pc_nxt;
  logic [31:0]   pend_pc_q, pend_pc_nxt;
  logic          pend_valid_q, pend_valid_nxt;
  // PC of the next response that will be kept; redirects restart it at the
  // target, so no per-request PC tracking is needed.
  logic [31:0]   rsp_pc_q, rsp_pc_nxt;
  logic          started_q;
  logic [63:0]   mem_q [DEPTH];

  logic [CW:0]   credit_sum;
  logic          hs, deq, redir, stalled, rsp_drop, enq;
  logic [31:0]   redir_pc;
  logic [63:0]   head;

  // Credits cover both in-flight and buffered fetches so the queue can
  // always absorb every response that comes back.
  assign credit_sum  = {1'b0, outstanding_q} + {1'b0, count_q};
  assign req_valid_o = started_q && (credit_sum < DEPTH_C);
  assign req_pc_o    = req_pc_q;

  assign hs       = req_valid_o && req_ready_i;
  assign deq      = inst_valid_o && inst_ready_i;
  assign redir    = int_i || redirect_i;
  assign redir_pc = int_i ? int_pc_i : redirect_pc_i;
  assign stalled  = req_valid_o && !req_ready_i;
  assign rsp_drop = rsp_valid_i && (drop_q != '0);
  assign enq      = rsp_valid_i && !rsp_drop && !redir;

  assign outstanding_nxt = outstanding_q + CW'(hs) - CW'(rsp_valid_i);

  always_comb begin
    drop_nxt       = drop_q;
    req_pc_nxt     = req_pc_q;
    pend_pc_nxt    = pend_pc_q;
    pend_valid_nxt = pend_valid_q;
    rsp_pc_nxt     = rsp_pc_q;
    count_nxt      = count_q;
    wr_ptr_nxt     = wr_ptr_q;
    rd_ptr_nxt     = rd_ptr_q;

    if (rsp_drop) drop_nxt = drop_q - ONE_C;

    if (redir) begin
      // Everything in flight, including a request accepted this cycle,
      // belongs to the old path.
      drop_nxt   = outstanding_nxt;
      rsp_pc_nxt = redir_pc;
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      if (stalled) begin
        // The stalled request must still complete, so the target waits.
        pend_valid_nxt = 1'b1;
        pend_pc_nxt    = redir_pc;
      end else begin
        pend_valid_nxt = 1'b0;
        req_pc_nxt     = redir_pc;
      end
    end else begin
      if (hs) begin
        if (pend_valid_q) begin
          // The request that was stalled across the redirect is stale.
          req_pc_nxt = pend_pc_q;
          drop_nxt   = drop_nxt + ONE_C;
        end else begin
          req_pc_nxt = req_pc_q + PC_STEP;
        end
        pend_valid_nxt = 1'b0;
      end
      if (enq) begin
        rsp_pc_nxt = rsp_pc_q + PC_STEP;
        wr_ptr_nxt = wr_ptr_q + PONE_C;
      end
      if (deq) rd_ptr_nxt = rd_ptr_q + PONE_C;
      count_nxt = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started_q     <= 1'b0;
      outstanding_q <= '0;
      count_q       <= '0;
      drop_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      req_pc_q      <= RESET_PC;
      pend_pc_q     <= '0;
      pend_valid_q  <= 1'b0;
      rsp_pc_q      <= RESET_PC;
    end else begin
      started_q     <= 1'b1;
      outstanding_q <= outstanding_nxt;
      count_q       <= count_nxt;
      drop_q        <= drop_nxt;
      wr_ptr_q      <= wr_ptr_nxt;
      rd_ptr_q      <= rd_ptr_nxt;
      req_pc_q      <= req_pc_nxt;
      pend_pc_q     <= pend_pc_nxt;
      pend_valid_q  <= pend_valid_nxt;
      rsp_pc_q      <= rsp_pc_nxt;
    end
  end

  // Storage needs no reset: the head is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= {rsp_pc_q, rsp_inst_i};
  end

  assign head         = mem_q[rd_ptr_q];
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? head[31:0]  : 32'h0;
  assign pc_o         = inst_valid_o ? head[63:32] : 32'h0;
  assign pc_4_o       = pc_o + 32'd4;

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue. A behavioural IROM returns ~pc as the
// instruction after a selectable latency of 1 or 2 cycles.
module tb_fetch_pc_queue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] req_pc_o;
  logic        req_valid_o;
  logic        req_ready_i = 1'b1;
  logic [31:0] rsp_inst_i = '0;
  logic        rsp_valid_i = 1'b0;
  logic        int_i = 1'b0;
  logic [31:0] int_pc_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o, pc_o, pc_4_o;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int hs_cnt;
  logic seen_600;

  fetch_pc_queue dut (
    .clk(clk), .resetn(resetn),
    .req_pc_o(req_pc_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .rsp_inst_i(rsp_inst_i), .rsp_valid_i(rsp_valid_i),
    .int_i(int_i), .int_pc_i(int_pc_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .pc_o(pc_o), .pc_4_o(pc_4_o)
  );

  always #5 clk = ~clk;

  // IROM model: delay line of accepted requests.
  logic        pv [4];
  logic [31:0] pa [4];
  initial for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pa[k] = '0; end

  always @(posedge clk) begin
    logic        h;
    logic [31:0] a;
    h = req_valid_o & req_ready_i;
    a = req_pc_o;
    #1;
    if (!resetn) begin
      for (int k = 0; k < 4; k++) pv[k] = 1'b0;
      rsp_valid_i = 1'b0;
      rsp_inst_i  = '0;
    end else begin
      for (int k = 3; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
      pv[0] = h;
      pa[0] = a;
      rsp_valid_i = pv[lat-1];
      rsp_inst_i  = pv[lat-1] ? ~pa[lat-1] : 32'h0;
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_cnt   <= 0;
      seen_600 <= 1'b0;
    end else if (req_valid_o && req_ready_i) begin
      hs_cnt <= hs_cnt + 1;
      if (req_pc_o == 32'h80000600) seen_600 <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int l);
    resetn = 1'b0;
    int_i = 1'b0; redirect_i = 1'b0;
    req_ready_i = 1'b1; inst_ready_i = 1'b1;
    repeat (2) tick();
    lat = l;
    resetn = 1'b1;
  endtask

  // Consumes n head entries with inst_ready_i high, expecting a sequential
  // run of PCs starting at start_pc.
  task automatic consume(input string tag, input logic [31:0] start_pc, input int n, input int maxc);
    logic [31:0] exp_pc;
    int got, c;
    exp_pc = start_pc;
    got = 0;
    c = 0;
    while (got < n && c < maxc) begin
      if (inst_valid_o) begin
        chk({tag, "_pc"}, pc_o, exp_pc);
        chk({tag, "_inst"}, inst_o, ~exp_pc);
        chk({tag, "_pc4"}, pc_4_o, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
      c++;
    end
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    inst_ready_i = 1'b0;
    repeat (2) tick();
    chk("rst_req_valid", req_valid_o, 0);
    chk("rst_req_pc", req_pc_o, 32'hbfc00000);
    chk("rst_inst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", pc_o, 0);

    // 1: first fetch, latency 1
    lat = 1;
    resetn = 1'b1;
    tick();
    chk("t1_req_valid", req_valid_o, 1);
    chk("t1_req_pc0", req_pc_o, 32'hbfc00000);
    tick();
    chk("t1_req_pc1", req_pc_o, 32'hbfc00004);
    chk("t1_not_yet_valid", inst_valid_o, 0);
    tick();
    chk("t1_inst_valid", inst_valid_o, 1);
    chk("t1_pc", pc_o, 32'hbfc00000);
    chk("t1_pc4", pc_4_o, 32'hbfc00004);
    chk("t1_inst", inst_o, ~32'hbfc00000);

    // 2: decode stalled, credits run out at DEPTH, then drain in order
    repeat (10) tick();
    chk("t2_hs_cnt", hs_cnt, 4);
    chk("t2_req_valid", req_valid_o, 0);
    chk("t2_head_held", pc_o, 32'hbfc00000);
    inst_ready_i = 1'b1;
    consume("t2_drain", 32'hbfc00000, 6, 40);

    // 3: two in flight, branch redirect
    do_reset(2);
    repeat (3) tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h80000100;
    tick();
    redirect_i = 1'b0;
    chk("t3_flush_empty", inst_valid_o, 0);
    chk("t3_req_pc", req_pc_o, 32'h80000100);
    consume("t3_after", 32'h80000100, 3, 20);

    // 4: redirects while the request is stalled
    do_reset(1);
    repeat (3) tick();
    req_ready_i = 1'b0;
    tick();
    chk("t4_stall_valid", req_valid_o, 1);
    chk("t4_stall_pc", req_pc_o, 32'hbfc00008);
    redirect_i = 1'b1; redirect_pc_i = 32'h80000200;
    tick();
    redirect_i = 1'b0;
    chk("t4_hold_pc_a", req_pc_o, 32'hbfc00008);
    int_i = 1'b1; int_pc_i = 32'h80000380;
    tick();
    int_i = 1'b0;
    tick();
    chk("t4_hold_pc_b", req_pc_o, 32'hbfc00008);
    req_ready_i = 1'b1;
    tick();
    chk("t4_next_req", req_pc_o, 32'h80000380);
    consume("t4_after", 32'h80000380, 3, 20);

    // 5: int and redirect together, interrupt wins
    do_reset(1);
    repeat (2) tick();
    int_i = 1'b1; int_pc_i = 32'h80000500;
    redirect_i = 1'b1; redirect_pc_i = 32'h80000600;
    tick();
    int_i = 1'b0; redirect_i = 1'b0;
    chk("t5_req_pc", req_pc_o, 32'h80000500);
    consume("t5_after", 32'h80000500, 3, 20);
    chk("t5_never_600", seen_600, 0);

    // 6: PC wrap, then async reset mid-burst
    do_reset(1);
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'hfffffff8;
    tick();
    redirect_i = 1'b0;
    tick();
    chk("t6_req_fffffffc", req_pc_o, 32'hfffffffc);
    tick();
    chk("t6_req_wrap", req_pc_o, 32'h00000000);
    consume("t6_wrap", 32'hfffffff8, 3, 20);
    #3;
    resetn = 1'b0;
    #1;
    chk("t6_async_req_valid", req_valid_o, 0);
    chk("t6_async_req_pc", req_pc_o, 32'hbfc00000);
    chk("t6_async_inst_valid", inst_valid_o, 0);
    chk("t6_async_inst", inst_o, 0);
    chk("t6_async_pc", pc_o, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
